traffic_gen: RTL and testbench

//  Parametrised pseudo-random bus-traffic generator driving the memory/cache under test.

---
 rtl/traffic_gen.sv | 131 +++++++++++++
 tb/tb_traffic_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_gen.sv
// traffic_gen
//   Pseudo-random bus-traffic generator for exercising a memory/cache target.
//   Address comes from an LFSR (mode 0) or a +1 walk (mode 1). Write data comes
//   from a second LFSR. Each run issues NUM_REQ transactions over a req/ack
//   handshake, then stops and raises done. Read data from read transactions is
//   folded into an XOR checksum.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a run (sampled only when not busy)
//   mode       in   0 = LFSR address, 1 = sequential address (latched at start)
//   req        out  transaction valid
//   ack        in   target accepts; a transfer completes on an edge with req & ack
//   rwb        out  1 = read, 0 = write (taken from wdata[DATA_W-3])
//   addr       out  transaction address
//   wdata      out  write data
//   rdata      in   read data, sampled on the accepting edge when rwb = 1
//   busy       out  run in progress
//   done       out  run complete, held until the next start
//   txn_count  out  accepted transactions in the current/last run
//   checksum   out  XOR of read data accepted in the current/last run
module traffic_gen #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int NUM_REQ = 16,
  parameter logic [ADDR_W-1:0] ADDR_SEED = 6'h20,
  parameter logic [DATA_W-1:0] DATA_SEED = 8'h80,
  localparam int CNT_W = $clog2(NUM_REQ + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  output logic              req,
  input  logic              ack,
  output logic              rwb,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  txn_count,
  output logic [DATA_W-1:0] checksum
);

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [ADDR_W-1:0] ADDR_INIT =
    (ADDR_SEED == '0) ? {{(ADDR_W-1){1'b0}}, 1'b1} : ADDR_SEED;
  localparam logic [DATA_W-1:0] DATA_INIT =
    (DATA_SEED == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : DATA_SEED;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;
  logic   mode_reg;

  function automatic logic [ADDR_W-1:0] addr_lfsr(input logic [ADDR_W-1:0] x);
    return {x[ADDR_W-2:0], x[ADDR_W-1] ^ x[ADDR_W-2]};
  endfunction

  function automatic logic [DATA_W-1:0] data_lfsr(input logic [DATA_W-1:0] x);
    return {x[DATA_W-2:0], x[DATA_W-1] ^ x[DATA_W-2]};
  endfunction

  // Direction is a bit of the registered write data, so it stays a flop output
  // and is stable for as long as wdata is.
  assign rwb = wdata[DATA_W-3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mode_reg  <= 1'b0;
      req       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      txn_count <= '0;
      checksum  <= '0;
      addr      <= ADDR_INIT;
      wdata     <= DATA_INIT;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg <= RUN;
            mode_reg  <= mode;
            addr      <= ADDR_INIT;
            wdata     <= DATA_INIT;
            txn_count <= '0;
            checksum  <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            req       <= 1'b1;
          end
        end
        RUN: begin
          // Without ack everything holds, so a stall of any length is invisible
          // to the target apart from its duration.
          if (req && ack) begin
            txn_count <= txn_count + 1'b1;
            if (rwb) begin
              checksum <= checksum ^ rdata;
            end
            if (txn_count == LAST_CNT) begin
              // Final accept: addr/wdata keep the last transaction's values.
              // A start arriving on this edge is deliberately not seen.
              state_reg <= DONE;
              req       <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              addr  <= mode_reg ? addr + 1'b1 : addr_lfsr(addr);
              wdata <= data_lfsr(wdata);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          req       <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_gen.sv
// tb_traffic_gen
//   Directed bench for traffic_gen with three instances:
//     u0: NUM_REQ=4, default seeds     (reset, LFSR run, stall, start-in-run, mid-run reset)
//     u1: NUM_REQ=4, ADDR 3E, DATA 20  (sequential wrap, checksum, start on final accept)
//     u2: default NUM_REQ, DATA seed 0 (seed replacement, full-length run)
module tb_traffic_gen;

  logic clk;
  logic rst_n;

  logic       start0, mode0, ack0, req0, rwb0, busy0, done0;
  logic [5:0] addr0;
  logic [7:0] wdata0, rdata0, csum0;
  logic [2:0] cnt0;

  logic       start1, mode1, ack1, req1, rwb1, busy1, done1;
  logic [5:0] addr1;
  logic [7:0] wdata1, rdata1, csum1;
  logic [2:0] cnt1;

  logic       start2, mode2, ack2, req2, rwb2, busy2, done2;
  logic [5:0] addr2;
  logic [7:0] wdata2, rdata2, csum2;
  logic [4:0] cnt2;

  int checks;
  int failures;

  traffic_gen #(.ADDR_W(6), .DATA_W(8), .NUM_REQ(4), .ADDR_SEED(6'h20), .DATA_SEED(8'h80)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .req(req0), .ack(ack0),
    .rwb(rwb0), .addr(addr0), .wdata(wdata0), .rdata(rdata0), .busy(busy0),
    .done(done0), .txn_count(cnt0), .checksum(csum0)
  );

  traffic_gen #(.ADDR_W(6), .DATA_W(8), .NUM_REQ(4), .ADDR_SEED(6'h3E), .DATA_SEED(8'h20)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .req(req1), .ack(ack1),
    .rwb(rwb1), .addr(addr1), .wdata(wdata1), .rdata(rdata1), .busy(busy1),
    .done(done1), .txn_count(cnt1), .checksum(csum1)
  );

  traffic_gen #(.ADDR_W(6), .DATA_W(8), .NUM_REQ(16), .ADDR_SEED(6'h20), .DATA_SEED(8'h00)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .req(req2), .ack(ack2),
    .rwb(rwb2), .addr(addr2), .wdata(wdata2), .rdata(rdata2), .busy(busy2),
    .done(done2), .txn_count(cnt2), .checksum(csum2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  logic [5:0] t2_addr  [4] = '{6'h20, 6'h01, 6'h02, 6'h04};
  logic [7:0] t2_wdata [4] = '{8'h80, 8'h01, 8'h02, 8'h04};
  logic [5:0] t4_addr  [4] = '{6'h3E, 6'h3F, 6'h00, 6'h01};
  logic [7:0] t5_wdata [4] = '{8'h20, 8'h40, 8'h81, 8'h03};
  logic       t5_rwb   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start0 = 0; mode0 = 0; ack0 = 0; rdata0 = 8'h00;
    start1 = 0; mode1 = 0; ack1 = 0; rdata1 = 8'h00;
    start2 = 0; mode2 = 0; ack2 = 0; rdata2 = 8'h00;

    // T1: reset values
    @(negedge clk);
    check("t1_req", req0, 1'b0);
    check("t1_busy", busy0, 1'b0);
    check("t1_done", done0, 1'b0);
    check("t1_addr", addr0, 6'h20);
    check("t1_wdata", wdata0, 8'h80);
    check("t1_rwb", rwb0, 1'b0);
    check("t1_cnt", cnt0, 0);
    check("t1_csum", csum0, 8'h00);
    check("t1_u2_wdata_zero_seed", wdata2, 8'h01);
    rst_n = 1'b1;

    // T2: LFSR run with ack held high (ack during IDLE must be ignored)
    @(negedge clk);
    start0 = 1; mode0 = 0; ack0 = 1;
    @(negedge clk);
    start0 = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_req[%0d]", i), req0, 1'b1);
      check($sformatf("t2_addr[%0d]", i), addr0, t2_addr[i]);
      check($sformatf("t2_wdata[%0d]", i), wdata0, t2_wdata[i]);
      check($sformatf("t2_rwb[%0d]", i), rwb0, 1'b0);
      check($sformatf("t2_cnt[%0d]", i), cnt0, i);
      check($sformatf("t2_done[%0d]", i), done0, 1'b0);
      @(negedge clk);
    end
    check("t2_done", done0, 1'b1);
    check("t2_busy", busy0, 1'b0);
    check("t2_req_off", req0, 1'b0);
    check("t2_cnt_final", cnt0, 4);
    check("t2_addr_hold", addr0, 6'h04);
    check("t2_wdata_hold", wdata0, 8'h04);

    // T3: stall on the second transfer
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    check("t3_done_clr", done0, 1'b0);
    check("t3_addr0", addr0, 6'h20);
    check("t3_cnt0", cnt0, 0);
    @(negedge clk);
    check("t3_addr1", addr0, 6'h01);
    check("t3_cnt1", cnt0, 1);
    ack0 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t3_stall_addr[%0d]", i), addr0, 6'h01);
      check($sformatf("t3_stall_wdata[%0d]", i), wdata0, 8'h01);
      check($sformatf("t3_stall_req[%0d]", i), req0, 1'b1);
      check($sformatf("t3_stall_cnt[%0d]", i), cnt0, 1);
    end
    ack0 = 1;
    @(negedge clk);
    check("t3_addr2", addr0, 6'h02);
    check("t3_wdata2", wdata0, 8'h02);
    check("t3_cnt2", cnt0, 2);

    // T6: start during RUN is ignored, then reset mid-run
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    check("t6_no_reload_addr", addr0, 6'h04);
    check("t6_cnt3", cnt0, 3);
    check("t6_busy", busy0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_req", req0, 1'b0);
    check("t6_rst_busy", busy0, 1'b0);
    check("t6_rst_done", done0, 1'b0);
    check("t6_rst_addr", addr0, 6'h20);
    check("t6_rst_wdata", wdata0, 8'h80);
    check("t6_rst_cnt", cnt0, 0);
    check("t6_rst_csum", csum0, 8'h00);
    check("t6_u2_wdata_zero_seed", wdata2, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    ack0 = 0;

    // T4/T5: sequential wrap, checksum, start on final accept
    @(negedge clk);
    start1 = 1; mode1 = 1; ack1 = 1; rdata1 = 8'h3C;
    @(negedge clk);
    start1 = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_addr[%0d]", i), addr1, t4_addr[i]);
      check($sformatf("t5_wdata[%0d]", i), wdata1, t5_wdata[i]);
      check($sformatf("t5_rwb[%0d]", i), rwb1, t5_rwb[i]);
      check($sformatf("t5_csum[%0d]", i), csum1, (i == 0) ? 8'h00 : 8'hA5);
      check($sformatf("t4_cnt[%0d]", i), cnt1, i);
      rdata1 = (i == 0) ? 8'hA5 : 8'h3C;
      mode1 = 1'b0;
      if (i == 3) start1 = 1;
      @(negedge clk);
    end
    start1 = 0;
    check("t5_done", done1, 1'b1);
    check("t5_req_off", req1, 1'b0);
    check("t5_busy", busy1, 1'b0);
    check("t5_cnt_final", cnt1, 4);
    check("t5_csum_final", csum1, 8'hA5);
    @(negedge clk);
    check("t5_start_ignored_req", req1, 1'b0);
    check("t5_start_ignored_done", done1, 1'b1);
    check("t5_ack_idle_csum", csum1, 8'hA5);
    check("t5_ack_idle_cnt", cnt1, 4);
    ack1 = 0;

    // Full-length run on the default-size instance with a zero data seed
    start2 = 1; ack2 = 1; mode2 = 0;
    @(negedge clk);
    start2 = 0;
    repeat (15) @(negedge clk);
    check("u2_cnt15", cnt2, 15);
    check("u2_done_early", done2, 1'b0);
    check("u2_busy", busy2, 1'b1);
    @(negedge clk);
    check("u2_done", done2, 1'b1);
    check("u2_cnt16", cnt2, 16);
    check("u2_addr_last", addr2, 6'h14);
    check("u2_wdata_last", wdata2, 8'h82);
    ack2 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
